vga_sync_receiver: RTL and testbench

- Receiving end of the 640x480 VGA timing interface. Consumes hsync/vsync plus the 25 MHz pixel-enable tick from the sync generator, or from any external source on the same board.
- Recovers pixel coordinates locked to the sync edges and measures line/frame periods against nominal values. Reports lock status, timing errors and video_on.
- Used for loopback self-check of the sync generator and to drive pixel consumers from an external timing source.

---
 rtl/vga_sync_receiver.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Receiving end of a VGA timing link: recovers pixel coordinates from the
// sync edges, measures line/frame periods and tracks lock against nominal timing.
module vga_sync_receiver #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_TOTAL     = 800,
    parameter int   HSYNC_START = 656,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_TOTAL     = 525,
    parameter int   VSYNC_START = 490,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pixelx,
    output logic [9:0] pixely,
    output logic       video_on,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic [9:0] line_len,
    output logic       frame_start
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  X_SYNC   = 10'(HSYNC_START);
    localparam logic [9:0]  Y_SYNC   = 10'(VSYNC_START);
    localparam logic [9:0]  X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] H_PERIOD = 11'(H_TOTAL);
    localparam logic [9:0]  V_PERIOD = 10'(V_TOTAL);
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [2:0]  LOCK_N   = 3'(LOCK_FRAMES);

    logic        r_hs_s, r_vs_s, r_hs_prev, r_vs_prev;
    logic [9:0]  r_x, r_y, r_hp, r_vp, r_line_len;
    logic        r_h_seen, r_v_seen, r_h_err_seen;
    logic        r_h_err, r_v_err, r_frame_start, r_locked, r_video_on;
    logic [2:0]  r_good_cnt;
    lock_state_t r_state;

    logic        w_hedge, w_vedge, w_x_wrap;
    logic [9:0]  w_x_next, w_y_next, w_hp_inc, w_vp_inc;
    logic [10:0] w_hp_plus1;
    logic        w_h_bad, w_h_timeout, w_h_err, w_v_bad, w_frame_good;
    logic [2:0]  w_good_next;
    lock_state_t w_state_next;

    assign w_hedge      = tick & r_hs_s & ~r_hs_prev;
    assign w_vedge      = tick & r_vs_s & ~r_vs_prev;
    assign w_x_wrap     = (r_x == X_LAST);
    assign w_hp_plus1   = {1'b0, r_hp} + 11'd1;
    // line_len saturates rather than wrapping to 0 after a sync timeout
    assign w_hp_inc     = (r_hp == CNT_MAX) ? CNT_MAX : r_hp + 10'd1;
    assign w_vp_inc     = (r_vp == CNT_MAX) ? CNT_MAX : r_vp + 10'd1;
    assign w_h_bad      = w_hedge & r_h_seen & (w_hp_plus1 != H_PERIOD);
    assign w_h_timeout  = tick & ~w_hedge & (r_hp == (CNT_MAX - 10'd1));
    assign w_h_err      = w_h_bad | w_h_timeout;
    assign w_v_bad      = w_vedge & r_v_seen & (r_vp != V_PERIOD);
    assign w_frame_good = w_vedge & r_v_seen & (r_vp == V_PERIOD) & ~r_h_err_seen & ~w_h_err;

    // Next coordinates: sync edges re-seed, otherwise free-run and wrap
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_hedge) begin
            w_x_next = X_SYNC;
        end else if (w_x_wrap) begin
            w_x_next = 10'd0;
        end else begin
            w_x_next = r_x + 10'd1;
        end
        if (w_vedge) begin
            w_y_next = Y_SYNC;
        end else if (w_x_wrap && !w_hedge) begin
            w_y_next = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
            w_y_next = r_y;
        end
    end

    // Input stage: normalise sync polarity every clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_s <= 1'b0;
            r_vs_s <= 1'b0;
        end else begin
            r_hs_s <= (hsync_in == SYNC_POL);
            r_vs_s <= (vsync_in == SYNC_POL);
        end
    end

    // Coordinate counters, period counters and seen flags, advanced per tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_prev    <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_hp         <= 10'd0;
            r_vp         <= 10'd0;
            r_h_seen     <= 1'b0;
            r_v_seen     <= 1'b0;
            r_h_err_seen <= 1'b0;
        end else if (tick) begin
            r_hs_prev <= r_hs_s;
            r_vs_prev <= r_vs_s;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_hp      <= w_hedge ? 10'd0 : w_hp_inc;
            if (w_vedge) begin
                r_vp <= 10'd0;
            end else if (w_hedge) begin
                r_vp <= w_vp_inc;
            end
            if (w_h_timeout) begin
                r_h_seen <= 1'b0;
            end else if (w_hedge) begin
                r_h_seen <= 1'b1;
            end
            if (w_vedge) begin
                r_v_seen <= 1'b1;
            end
            // a line error taints the frame being measured up to the next vedge
            if (w_vedge) begin
                r_h_err_seen <= 1'b0;
            end else if (w_h_err) begin
                r_h_err_seen <= 1'b1;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
        end
    end

    // Lock FSM next state: errors override everything, timeout fully unlocks
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        if (w_h_timeout) begin
            w_state_next = ST_UNLOCKED;
            w_good_next  = 3'd0;
        end else if (w_h_err || w_v_bad) begin
            w_state_next = ST_ACQUIRE;
            w_good_next  = 3'd0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_vedge) begin
                        w_state_next = ST_ACQUIRE;
                        w_good_next  = 3'd0;
                    end else begin
                        w_state_next = ST_UNLOCKED;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_frame_good) begin
                        w_good_next = r_good_cnt + 3'd1;
                        if ((r_good_cnt + 3'd1) >= LOCK_N) begin
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_state_next = ST_ACQUIRE;
                        end
                    end else begin
                        w_state_next = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    w_state_next = ST_LOCKED;
                end
                default: begin
                    w_state_next = ST_UNLOCKED;
                    w_good_next  = 3'd0;
                end
            endcase
        end
    end

    // Registered outputs; pulses only ever fire on tick cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_video_on    <= 1'b0;
            r_line_len    <= 10'd0;
        end else begin
            r_h_err       <= w_h_err;
            r_v_err       <= w_v_bad;
            r_frame_start <= tick & (w_x_next == 10'd0) & (w_y_next == 10'd0);
            if (tick) begin
                r_locked   <= (w_state_next == ST_LOCKED);
                r_video_on <= (w_state_next == ST_LOCKED) & (w_x_next < X_ACT) & (w_y_next < Y_ACT);
                if (w_hedge) begin
                    r_line_len <= w_hp_inc;
                end
            end
        end
    end

    assign pixelx      = r_x;
    assign pixely      = r_y;
    assign video_on    = r_video_on;
    assign locked      = r_locked;
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;
    assign line_len    = r_line_len;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomised bench for vga_sync_receiver on a shrunken raster, checked every
// clk against a tick-indexed reference model of the receiver's rules.
module tb_vga_sync_receiver;
    localparam int   HA  = 16;
    localparam int   HT  = 24;
    localparam int   HS  = 18;
    localparam int   HW  = 3;
    localparam int   VA  = 8;
    localparam int   VT  = 12;
    localparam int   VS  = 9;
    localparam int   LF  = 2;
    localparam logic POL = 1'b0;
    localparam int   FRAME = HT * VT;

    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic       hsync_in = ~POL, vsync_in = ~POL;
    logic [9:0] pixelx, pixely, line_len;
    logic       video_on, locked, h_err, v_err, frame_start;

    int n_checks = 0, n_errors = 0;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HS), .V_ACTIVE(VA),
        .V_TOTAL(VT), .VSYNC_START(VS), .SYNC_POL(POL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixelx(pixelx), .pixely(pixely), .video_on(video_on), .locked(locked),
        .h_err(h_err), .v_err(v_err), .line_len(line_len), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_hs_s, m_vs_s, m_hs_prev, m_vs_prev;
    bit m_h_seen, m_v_seen, m_herr_in_frame;
    int m_n, m_ref, m_hcnt, m_state, m_good;   // m_state: 0 unlocked, 1 acquire, 2 locked
    int e_x, e_y, e_len;
    bit e_video, e_locked, e_herr, e_verr, e_fs;

    task automatic model_reset();
        m_hs_s = 0; m_vs_s = 0; m_hs_prev = 0; m_vs_prev = 0;
        m_h_seen = 0; m_v_seen = 0; m_herr_in_frame = 0;
        m_n = 0; m_ref = 0; m_hcnt = 0; m_state = 0; m_good = 0;
        e_x = 0; e_y = 0; e_len = 0;
        e_video = 0; e_locked = 0; e_herr = 0; e_verr = 0; e_fs = 0;
    endtask

    task automatic model_tick();
        bit hedge, vedge, timeout, herr, vbad, good, wrap;
        int elapsed;
        hedge = m_hs_s && !m_hs_prev;
        vedge = m_vs_s && !m_vs_prev;
        m_hs_prev = m_hs_s;
        m_vs_prev = m_vs_s;
        m_n++;
        elapsed = m_n - m_ref;
        timeout = !hedge && (elapsed == 1023);
        herr    = (hedge && m_h_seen && elapsed != HT) || timeout;
        vbad    = vedge && m_v_seen && (m_hcnt != VT);
        good    = vedge && m_v_seen && (m_hcnt == VT) && !m_herr_in_frame && !herr;
        wrap    = (e_x == HT - 1) && !hedge;
        e_x = hedge ? HS : (e_x + 1) % HT;
        if (vedge) e_y = VS;
        else if (wrap) e_y = (e_y + 1) % VT;
        if (hedge) begin
            e_len = (elapsed > 1023) ? 1023 : elapsed;
            m_ref = m_n;
            m_h_seen = 1;
        end
        if (timeout) m_h_seen = 0;
        if (vedge) begin
            m_hcnt = 0; m_v_seen = 1; m_herr_in_frame = 0;
        end else begin
            if (hedge) m_hcnt++;
            if (herr) m_herr_in_frame = 1;
        end
        if (timeout) begin
            m_state = 0; m_good = 0;
        end else if (herr || vbad) begin
            m_state = 1; m_good = 0;
        end else if (m_state == 0) begin
            if (vedge) m_state = 1;
        end else if (m_state == 1 && good) begin
            m_good++;
            if (m_good >= LF) m_state = 2;
        end
        e_locked = (m_state == 2);
        e_video  = e_locked && (e_x < HA) && (e_y < VA);
        e_herr   = herr;
        e_verr   = vbad;
        e_fs     = (e_x == 0) && (e_y == 0);
    endtask

    // ---------------- sync generator ----------------
    int g_x, g_y, g_line_len = HT, g_frame_len = VT;
    bit g_short_req, g_long_req, g_hkill;

    task automatic gen_drive();
        bit hs, vs;
        hs = !g_hkill && g_x >= HS && g_x < HS + HW;
        vs = g_y >= VS && g_y < VS + 2;
        hsync_in = hs ? POL : ~POL;
        vsync_in = vs ? POL : ~POL;
    endtask

    task automatic gen_advance();
        if (g_x >= g_line_len - 1) begin
            g_x = 0;
            g_line_len = g_short_req ? HT - 1 : HT;
            g_short_req = 0;
            if (g_y >= g_frame_len - 1) begin
                g_y = 0;
                g_frame_len = g_long_req ? VT + 1 : VT;
                g_long_req = 0;
            end else begin
                g_y++;
            end
        end else begin
            g_x++;
        end
    endtask

    // ---------------- clocking, checking, monitoring ----------------
    int cnt_herr, cnt_verr, cnt_fs, cnt_vid;
    int herr_len, herr_locked, verr_locked;

    task automatic clear_counts();
        cnt_herr = 0; cnt_verr = 0; cnt_fs = 0; cnt_vid = 0;
    endtask

    task automatic clk_cycle(input bit t);
        tick = t;
        @(posedge clk);
        if (t) model_tick();
        else begin e_herr = 0; e_verr = 0; e_fs = 0; end
        m_hs_s = (hsync_in == POL);
        m_vs_s = (vsync_in == POL);
        @(negedge clk);
        tick = 1'b0;
        chk("pixelx", pixelx, e_x);
        chk("pixely", pixely, e_y);
        chk("video_on", video_on, e_video);
        chk("locked", locked, e_locked);
        chk("h_err", h_err, e_herr);
        chk("v_err", v_err, e_verr);
        chk("line_len", line_len, e_len);
        chk("frame_start", frame_start, e_fs);
        if (h_err) begin cnt_herr++; herr_len = line_len; herr_locked = locked; end
        if (v_err) begin cnt_verr++; verr_locked = locked; end
        if (frame_start) cnt_fs++;
        if (t && video_on) cnt_vid++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            gen_drive();
            repeat ($urandom_range(4, 1)) clk_cycle(1'b0);
            clk_cycle(1'b1);
            gen_advance();
        end
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_pixelx", pixelx, 0);
        chk("rst_pixely", pixely, 0);
        chk("rst_video_on", video_on, 0);
        chk("rst_locked", locked, 0);
        chk("rst_h_err", h_err, 0);
        chk("rst_v_err", v_err, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_start", frame_start, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        g_x = $urandom_range(HT - 1, 0);
        g_y = $urandom_range(VT - 1, 0);
        @(negedge clk);
        apply_reset();

        // nominal timing: lock, then one full measured frame
        run_ticks(6 * FRAME);
        chk("lock_nominal", locked, 1);
        clear_counts();
        run_ticks(FRAME);
        chk("video_ticks_per_frame", cnt_vid, HA * VA);
        chk("frame_starts_per_frame", cnt_fs, 1);
        chk("nominal_h_err", cnt_herr, 0);
        chk("nominal_v_err", cnt_verr, 0);
        chk("nominal_line_len", line_len, HT);

        // one short line while locked
        clear_counts();
        g_short_req = 1;
        run_ticks(3 * HT + 20);
        chk("short_h_err_count", cnt_herr, 1);
        chk("short_line_len", herr_len, HT - 1);
        chk("short_unlocked", herr_locked, 0);
        run_ticks(5 * FRAME);
        chk("short_relock", locked, 1);
        chk("short_h_err_total", cnt_herr, 1);

        // one long frame
        clear_counts();
        g_long_req = 1;
        run_ticks(4 * FRAME);
        chk("long_v_err_count", cnt_verr, 1);
        chk("long_unlocked", verr_locked, 0);
        run_ticks(4 * FRAME);
        chk("long_relock", locked, 1);

        // hsync held deasserted until hp saturates
        clear_counts();
        g_hkill = 1;
        run_ticks(1100);
        chk("timeout_h_err_count", cnt_herr, 1);
        chk("timeout_unlocked", locked, 0);
        g_hkill = 0;
        run_ticks(7 * FRAME);
        chk("timeout_relock", locked, 1);

        // tick held low: everything frozen, no pulses
        clear_counts();
        repeat (100) clk_cycle(1'b0);
        chk("freeze_pulses", cnt_herr + cnt_verr + cnt_fs, 0);

        // reset mid-frame, then relock from scratch
        run_ticks($urandom_range(FRAME, 1));
        apply_reset();
        clear_counts();
        run_ticks(5 * FRAME);
        chk("reset_relock", locked, 1);
        chk("reset_no_h_err", cnt_herr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
